// File: rtl/axicb_wch_scheduler.sv
// Write-channel scheduler: queues AW grants in order and routes each master's W burst
// to the slave once its AW entry reaches the head of the queue.
module axicb_wch_scheduler #(
  parameter int unsigned MST_NB = 4,
  parameter int unsigned WCH_W  = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      srst,
  input  logic [MST_NB-1:0]         aw_grant,
  input  logic                      aw_valid_in,
  input  logic                      aw_ready_in,
  output logic                      aw_valid_out,
  output logic                      aw_ready_out,
  input  logic [MST_NB-1:0]         i_wvalid,
  input  logic [MST_NB-1:0]         i_wlast,
  input  logic [MST_NB*WCH_W-1:0]   i_wch,
  output logic [MST_NB-1:0]         i_wready,
  output logic                      o_wvalid,
  output logic                      o_wlast,
  output logic [WCH_W-1:0]          o_wch,
  input  logic                      o_wready,
  output logic [MST_NB-1:0]         wch_grant,
  output logic [$clog2(DEPTH):0]    outstanding,
  output logic                      err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [MST_NB-1:0] fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              err_q;

  logic full;
  logic empty;
  logic grant_ok;
  logic push_hs;
  logic push;
  logic pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign grant_ok = $onehot(aw_grant);

  // A handshake with a malformed grant still completes on AW but is not queued.
  assign push_hs  = aw_valid_in & aw_ready_in & ~full;
  assign push     = push_hs & grant_ok;

  assign aw_valid_out = aw_valid_in & ~full;
  assign aw_ready_out = aw_ready_in & ~full;

  assign wch_grant = empty ? '0 : fifo_q[rd_ptr_q];
  assign i_wready  = wch_grant & {MST_NB{o_wready}};
  assign pop       = o_wvalid & o_wready & o_wlast;

  assign outstanding = count_q;
  assign err         = err_q;

  // Owner select; wch_grant is one-hot or zero so an OR-reduction mux suffices.
  always_comb begin
    o_wvalid = 1'b0;
    o_wlast  = 1'b0;
    o_wch    = '0;
    for (int unsigned m = 0; m < MST_NB; m++) begin
      if (wch_grant[m]) begin
        o_wvalid = o_wvalid | i_wvalid[m];
        o_wlast  = o_wlast | i_wlast[m];
        o_wch    = o_wch | i_wch[m*WCH_W +: WCH_W];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else if (srst) begin
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= aw_grant;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (push_hs && !grant_ok) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axicb_wch_scheduler.sv
// Bench for axicb_wch_scheduler: AW vector table, per-master burst models and a W-beat scoreboard.
module tb_axicb_wch_scheduler;

  localparam int unsigned MST_NB = 4;
  localparam int unsigned WCH_W  = 8;
  localparam int unsigned DEPTH  = 4;

  logic                    aclk = 1'b0;
  logic                    aresetn;
  logic                    srst;
  logic [MST_NB-1:0]       aw_grant;
  logic                    aw_valid_in;
  logic                    aw_ready_in;
  logic                    aw_valid_out;
  logic                    aw_ready_out;
  logic [MST_NB-1:0]       i_wvalid;
  logic [MST_NB-1:0]       i_wlast;
  logic [MST_NB*WCH_W-1:0] i_wch;
  logic [MST_NB-1:0]       i_wready;
  logic                    o_wvalid;
  logic                    o_wlast;
  logic [WCH_W-1:0]        o_wch;
  logic                    o_wready;
  logic [MST_NB-1:0]       wch_grant;
  logic [2:0]              outstanding;
  logic                    err;

  axicb_wch_scheduler #(.MST_NB(MST_NB), .WCH_W(WCH_W), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .aw_grant(aw_grant), .aw_valid_in(aw_valid_in), .aw_ready_in(aw_ready_in),
    .aw_valid_out(aw_valid_out), .aw_ready_out(aw_ready_out),
    .i_wvalid(i_wvalid), .i_wlast(i_wlast), .i_wch(i_wch), .i_wready(i_wready),
    .o_wvalid(o_wvalid), .o_wlast(o_wlast), .o_wch(o_wch), .o_wready(o_wready),
    .wch_grant(wch_grant), .outstanding(outstanding), .err(err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [MST_NB-1:0] grant;
    logic [WCH_W-1:0]  data;
    logic              last;
  } beat_t;

  typedef struct {
    logic              vin;
    logic              rin;
    logic [MST_NB-1:0] grant;
    logic              exp_vout;
    logic              exp_rout;
    logic [2:0]        exp_outst;
    bit                acc;
  } aw_vec_t;

  beat_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  int          len[MST_NB];
  int          beat[MST_NB];
  bit          active[MST_NB];
  logic [MST_NB-1:0] hs_q = '0;
  aw_vec_t     tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_masters();
    for (int m = 0; m < MST_NB; m++) begin
      i_wvalid[m] = active[m];
      i_wlast[m]  = active[m] && (beat[m] == len[m] - 1);
      i_wch[m*WCH_W +: WCH_W] = WCH_W'(m * 16 + beat[m]);
    end
  endtask

  task automatic expect_burst(input int m);
    for (int b = 0; b < len[m]; b++)
      sb.push_back('{MST_NB'(1 << m), WCH_W'(m * 16 + b), (b == len[m] - 1)});
  endtask

  // Advance one clock; master models consume the handshakes seen before the edge.
  task automatic tick();
    @(posedge aclk);
    #1;
    for (int m = 0; m < MST_NB; m++) begin
      if (hs_q[m]) begin
        if (beat[m] == len[m] - 1) begin
          active[m] = 1'b0;
          beat[m]   = 0;
        end else begin
          beat[m]++;
        end
      end
    end
    drive_masters();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() > 0; i++) tick();
    check(name, sb.size(), 0);
  endtask

  // Scoreboard monitor: every beat reaching the slave must match the queued expectation.
  always @(negedge aclk) begin
    beat_t e;
    hs_q = i_wvalid & i_wready;
    if (o_wvalid && o_wready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %0h grant %0h expected no beat", o_wch, wch_grant);
      end else begin
        e = sb.pop_front();
        check("w_data", o_wch, e.data);
        check("w_last", o_wlast, e.last);
        check("w_owner_ready", i_wready, e.grant);
      end
    end
  end

  initial begin
    aresetn = 1'b0; srst = 1'b0; aw_grant = '0; aw_valid_in = 1'b0; aw_ready_in = 1'b0;
    o_wready = 1'b1;
    for (int m = 0; m < MST_NB; m++) begin len[m] = 1; beat[m] = 0; active[m] = 1'b0; end
    drive_masters();
    tick();
    check("rst_outst", outstanding, 0);
    check("rst_err", err, 0);
    check("rst_grant", wch_grant, 0);
    check("rst_wvalid", o_wvalid, 0);
    check("rst_iwready", i_wready, 0);
    aw_valid_in = 1'b1; aw_ready_in = 1'b1;
    #1;
    check("rst_aw_vout", aw_valid_out, 1);
    check("rst_aw_rout", aw_ready_out, 1);
    aw_valid_in = 1'b0; aw_ready_in = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();

    // Single burst: no bypass, four beats on the cycles after the push.
    len[1] = 4; active[1] = 1'b1; drive_masters();
    aw_grant = 4'b0010; aw_valid_in = 1'b1; aw_ready_in = 1'b1;
    #1;
    check("single_nobypass", o_wvalid, 0);
    check("single_nobypass_rdy", i_wready, 0);
    expect_burst(1);
    tick();
    aw_valid_in = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check("single_outst", outstanding, 1);
      check("single_wvalid", o_wvalid, 1);
      check("single_iwready", i_wready, 4'b0010);
      tick();
    end
    #1;
    check("single_outst_end", outstanding, 0);
    check("single_wvalid_end", o_wvalid, 0);

    // Table-driven AW sequence filling the queue to full and probing it while full.
    for (int m = 0; m < MST_NB; m++) len[m] = 2;
    tbl[0] = '{1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 3'd1, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 3'd1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 3'd1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, 3'd2, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 3'd3, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 4'b1000, 1'b1, 1'b1, 3'd4, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 3'd4, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 4'b0011, 1'b0, 1'b0, 3'd4, 1'b0};
    for (int i = 0; i < 8; i++) begin
      aw_valid_in = tbl[i].vin; aw_ready_in = tbl[i].rin; aw_grant = tbl[i].grant;
      #1;
      check("tbl_aw_vout", aw_valid_out, tbl[i].exp_vout);
      check("tbl_aw_rout", aw_ready_out, tbl[i].exp_rout);
      if (tbl[i].acc)
        for (int m = 0; m < MST_NB; m++) if (tbl[i].grant[m]) expect_burst(m);
      tick();
      check("tbl_outst", outstanding, tbl[i].exp_outst);
    end
    check("full_err", err, 0);
    check("full_head", wch_grant, 4'b0001);

    // Drain in AW order; full must still block AW on the cycle of the pop.
    aw_valid_in = 1'b0; aw_ready_in = 1'b1;
    for (int m = 0; m < MST_NB; m++) active[m] = 1'b1;
    drive_masters();
    #1;
    check("full_rout_beat0", aw_ready_out, 0);
    tick();
    #1;
    check("full_rout_popcyc", aw_ready_out, 0);
    check("full_popcyc_last", o_wlast, 1);
    tick();
    #1;
    check("full_rout_after", aw_ready_out, 1);
    check("full_outst_after", outstanding, 3);
    drain("order_drain");
    #1;
    check("order_outst_end", outstanding, 0);

    // Simultaneous push and pop with two entries outstanding.
    for (int m = 0; m < MST_NB; m++) len[m] = 1;
    aw_grant = 4'b0001; aw_valid_in = 1'b1; aw_ready_in = 1'b1;
    tick();
    aw_grant = 4'b0010;
    tick();
    expect_burst(0); expect_burst(1);
    aw_valid_in = 1'b0;
    #1;
    check("sim_outst_pre", outstanding, 2);
    active[0] = 1'b1; drive_masters();
    aw_grant = 4'b0100; aw_valid_in = 1'b1;
    #1;
    check("sim_pop_valid", o_wvalid & o_wlast, 1);
    check("sim_push_rdy", aw_ready_out, 1);
    expect_burst(2);
    tick();
    aw_valid_in = 1'b0;
    #1;
    check("sim_outst", outstanding, 2);
    check("sim_head", wch_grant, 4'b0010);
    active[1] = 1'b1; active[2] = 1'b1; drive_masters();
    drain("sim_drain");
    #1;
    check("sim_outst_end", outstanding, 0);

    // Malformed grant sets sticky err without queuing.
    aw_grant = 4'b0011; aw_valid_in = 1'b1; aw_ready_in = 1'b1;
    #1;
    check("err_aw_rout", aw_ready_out, 1);
    tick();
    aw_valid_in = 1'b0;
    #1;
    check("err_set", err, 1);
    check("err_outst", outstanding, 0);
    tick();
    check("err_sticky", err, 1);

    // Async reset in the middle of a burst discards the queue.
    len[2] = 4; active[2] = 1'b1; drive_masters();
    aw_grant = 4'b0100; aw_valid_in = 1'b1;
    expect_burst(2);
    tick();
    aw_valid_in = 1'b0;
    tick();
    tick();
    aresetn = 1'b0;
    #1;
    sb.delete();
    check("arst_grant", wch_grant, 0);
    check("arst_wvalid", o_wvalid, 0);
    check("arst_wlast", o_wlast, 0);
    check("arst_wch", o_wch, 0);
    check("arst_iwready", i_wready, 0);
    check("arst_err", err, 0);
    check("arst_outst", outstanding, 0);
    tick();
    aresetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("arst_no_fwd", o_wvalid, 0);
      check("arst_no_rdy", i_wready, 0);
    end
    active[2] = 1'b0; beat[2] = 0; drive_masters();

    // Synchronous reset wins over a concurrent push.
    aw_grant = 4'b0001; aw_valid_in = 1'b1;
    tick();
    check("srst_pre_outst", outstanding, 1);
    srst = 1'b1;
    tick();
    srst = 1'b0; aw_valid_in = 1'b0;
    #1;
    check("srst_outst", outstanding, 0);
    check("srst_grant", wch_grant, 0);

    tick();
    check("sb_empty_end", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
